// File: rtl/alu_pkg.sv
// Shared widths and encodings for the ALU and the scheduler that fronts it.
package alu_pkg;
  localparam int OPCODE_W = 3;
  localparam int DATA_W   = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [7:0] mask, input logic [OPCODE_W-1:0] op);
    return mask[op];
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester after `last`, wrapping
// modulo N. The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the search leaves a value held over (which would infer a latch).
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(last) + i) % N);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end
endmodule

// File: rtl/alu_sched.sv
// Round-robin front end that serialises N requesters onto one shared ALU and
// routes each captured result back to the requester that issued it.
module alu_sched
  import alu_pkg::*;
#(
  parameter int         N       = 4,
  parameter int         ALU_LAT = 1,
  parameter int         RES_W   = 5,
  parameter logic [7:0] OP_MASK = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [OPCODE_W*N-1:0] req_opcode,
  input  logic [DATA_W*N-1:0]   req_op1,
  input  logic [DATA_W*N-1:0]   req_op2,
  output logic [N-1:0]          rsp_valid,
  input  logic [N-1:0]          rsp_ready,
  output logic [RES_W-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic [OPCODE_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0]     alu_op1,
  output logic [DATA_W-1:0]     alu_op2,
  input  logic [RES_W-1:0]      alu_result,
  output logic                  busy
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  state_e              state;
  logic [IDX_W-1:0]    last;
  logic [IDX_W-1:0]    g;
  logic [CNT_W-1:0]    cnt;
  logic [N-1:0]        win;
  logic [IDX_W-1:0]    win_idx;
  logic [OPCODE_W-1:0] sel_op;
  logic [DATA_W-1:0]   sel_op1;
  logic [DATA_W-1:0]   sel_op2;

  // Grants are offered only in IDLE and never while reset is asserted.
  rr_arbiter #(.N(N)) u_arb (
    .req     (req_valid),
    .last    (last),
    .en      (state == IDLE && !rst),
    .gnt     (win),
    .gnt_idx (win_idx)
  );

  assign req_ready = win;
  assign busy      = (state != IDLE);
  assign sel_op    = req_opcode[win_idx*OPCODE_W +: OPCODE_W];
  assign sel_op1   = req_op1[win_idx*DATA_W +: DATA_W];
  assign sel_op2   = req_op2[win_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= IDX_W'(N - 1);
      g          <= '0;
      cnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      alu_opcode <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every register
      // samples pre-edge values, independent of statement order.
      case (state)
        IDLE: begin
          if (|win) begin
            g   <= win_idx;
            cnt <= CNT_W'(ALU_LAT);
            if (op_legal(OP_MASK, sel_op)) begin
              alu_opcode <= sel_op;
              alu_op1    <= sel_op1;
              alu_op2    <= sel_op2;
              state      <= WAIT;
            end else begin
              // Illegal opcodes never reach the ALU; answer with an error at once.
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= N'(1) << win_idx;
              state     <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_data  <= alu_result;
            rsp_err   <= 1'b0;
            rsp_valid <= N'(1) << g;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[g]) begin
            rsp_valid <= '0;
            last      <= g;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
